// File: rtl/toeplitz_pkg.sv
// -----------------------------------------------------------------------------
// toeplitz_pkg
// Shared definitions for the Toeplitz hash accumulator: default geometry,
// beat-count helpers used to size the beat counter, and the default hash type.
// -----------------------------------------------------------------------------
package toeplitz_pkg;

    localparam int DEF_N      = 256;  // raw block length in bits
    localparam int DEF_L      = 128;  // hash width in bits
    localparam int DEF_STRIDE = 1;    // bits / columns consumed per beat
    localparam int DEF_CW     = 32;   // completed-block counter width

    // Number of beats needed to consume one N-bit block.
    function automatic int beats(input int n, input int stride);
        return n / stride;
    endfunction

    // Beat counter width; a single-beat block still gets a 1-bit counter.
    function automatic int beat_w(input int n, input int stride);
        int w;
        w = $clog2(beats(n, stride));
        return (w < 1) ? 1 : w;
    endfunction

    typedef logic [DEF_L-1:0] hash_t;

endpackage

// File: rtl/toeplitz_acc_if.sv
// -----------------------------------------------------------------------------
// toeplitz_acc_if
// Bus bundle between the Toeplitz accumulator and its environment.
//   flush      : discard the partial block (synchronous)
//   din        : STRIDE raw bits of the current beat
//   din_valid  : din qualifier            din_ready : accumulator accepts din
//   cols       : STRIDE columns, column j at cols[j*L +: L]
//   col_adv    : beat accepted, generators step by STRIDE
//   col_wrap   : final beat of a block accepted, generators reload
//   dout       : last completed hash      dout_valid: dout not yet consumed
//   dout_ready : downstream takes dout    blk_cnt   : completed block count
//   dbg_beat   : current beat index, exposed for observation
// Modport slave is the accumulator; modport master is the environment.
// -----------------------------------------------------------------------------
interface toeplitz_acc_if
    import toeplitz_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int L      = DEF_L,
    parameter int STRIDE = DEF_STRIDE,
    parameter int CW     = DEF_CW
);

    logic                             flush;
    logic [STRIDE-1:0]                din;
    logic                             din_valid;
    logic                             din_ready;
    logic [STRIDE*L-1:0]              cols;
    logic                             col_adv;
    logic                             col_wrap;
    logic [L-1:0]                     dout;
    logic                             dout_valid;
    logic                             dout_ready;
    logic [CW-1:0]                    blk_cnt;
    logic [beat_w(N, STRIDE)-1:0]     dbg_beat;

    modport master (
        output flush, din, din_valid, cols, dout_ready,
        input  din_ready, col_adv, col_wrap, dout, dout_valid, blk_cnt, dbg_beat
    );

    modport slave (
        input  flush, din, din_valid, cols, dout_ready,
        output din_ready, col_adv, col_wrap, dout, dout_valid, blk_cnt, dbg_beat
    );

endinterface

// File: rtl/toeplitz_xor_tree.sv
// -----------------------------------------------------------------------------
// toeplitz_xor_tree
// Combinational GF(2) contribution of one beat: XOR of every column whose
// raw bit is set.
//   i_din     [STRIDE]   raw bits, i_din[j] selects column j
//   i_cols    [STRIDE*L] column group, column j at i_cols[j*L +: L]
//   o_contrib [L]        XOR of the selected columns
// -----------------------------------------------------------------------------
module toeplitz_xor_tree #(
    parameter int STRIDE = 1,
    parameter int L      = 128
) (
    input  logic [STRIDE-1:0]   i_din,
    input  logic [STRIDE*L-1:0] i_cols,
    output logic [L-1:0]        o_contrib
);

    logic [L-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < STRIDE; j++) begin
            if (i_din[j]) begin
                w_sum = w_sum ^ i_cols[j*L +: L];
            end
        end
    end

    assign o_contrib = w_sum;

endmodule

// File: rtl/toeplitz_acc.sv
// -----------------------------------------------------------------------------
// toeplitz_acc
// Accumulates the GF(2) product hash = M.x of an N-bit raw block against the
// Toeplitz columns supplied by a bank of column generators, STRIDE columns per
// beat, and emits one L-bit hash per block.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : toeplitz_acc_if.slave (input/output handshakes, column pacing,
//           hash output, completed-block counter, beat index)
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. din_ready does not depend on din_valid; dout_valid stays high and
// dout stays stable until dout_ready is seen, and dout_ready may be high at
// any time. col_adv/col_wrap are same-cycle strobes that mark the din
// transfer so the generators advance in lockstep with it.
// -----------------------------------------------------------------------------
module toeplitz_acc
    import toeplitz_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int L      = DEF_L,
    parameter int STRIDE = DEF_STRIDE,
    parameter int CW     = DEF_CW
) (
    input  logic           clk,
    input  logic           reset,
    toeplitz_acc_if.slave  bus
);

    localparam int             BEATS     = beats(N, STRIDE);
    localparam int             BW        = beat_w(N, STRIDE);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

    // Geometry sanity checks at elaboration.
    if ((N % STRIDE) != 0) begin : g_bad_n
        $error("toeplitz_acc: N must be a multiple of STRIDE");
    end
    if ((STRIDE < 1) || (STRIDE > 64) || ((STRIDE & (STRIDE - 1)) != 0)) begin : g_bad_stride
        $error("toeplitz_acc: STRIDE must be a power of two in 1..64");
    end

    logic [L-1:0]  r_acc;
    logic [BW-1:0] r_beat;
    logic [L-1:0]  r_dout;
    logic          r_dout_valid;
    logic [CW-1:0] r_blk_cnt;

    logic          w_last;
    logic          w_din_ready;
    logic          w_acc_beat;
    logic          w_done;
    logic [L-1:0]  w_contrib;
    logic [L-1:0]  w_acc_next;

    toeplitz_xor_tree #(
        .STRIDE (STRIDE),
        .L      (L)
    ) u_xor_tree (
        .i_din     (bus.din),
        .i_cols    (bus.cols),
        .o_contrib (w_contrib)
    );

    assign w_last = (r_beat == LAST_BEAT);

    // Only the final beat needs room in the output register; it may go ahead
    // when the register is empty or is being emptied in this same cycle.
    assign w_din_ready = !w_last || !r_dout_valid || bus.dout_ready;

    // Gated by reset so the generators see no strobe while reset is held.
    assign w_acc_beat = reset && bus.din_valid && w_din_ready && !bus.flush;
    assign w_done     = w_acc_beat && w_last;
    assign w_acc_next = r_acc ^ w_contrib;

    // Partial hash and beat position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (bus.flush) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (w_acc_beat) begin
            if (w_last) begin
                r_acc  <= '0;
                r_beat <= '0;
            end else begin
                r_acc  <= w_acc_next;
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Output register: a completion wins over a consume in the same cycle,
    // so back-to-back hashes leave no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_blk_cnt    <= '0;
        end else if (w_done) begin
            r_dout       <= w_acc_next;
            r_dout_valid <= 1'b1;
            r_blk_cnt    <= r_blk_cnt + 1'b1;
        end else if (r_dout_valid && bus.dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.col_adv    = w_acc_beat;
    assign bus.col_wrap   = w_done;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.blk_cnt    = r_blk_cnt;
    assign bus.dbg_beat   = r_beat;

endmodule

// File: tb/tb_toeplitz_acc.sv
// -----------------------------------------------------------------------------
// tb_toeplitz_acc
// Two accumulators (STRIDE=1 and STRIDE=4, N=256, L=128) driven with directed
// and random beats. The reference keeps the raw bits and columns of each block
// by column index and forms the hash as the XOR of the columns whose bit is 1.
// -----------------------------------------------------------------------------
module tb_toeplitz_acc;

    localparam int N  = 256;
    localparam int L  = 128;
    localparam int CW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    toeplitz_acc_if #(.N(N), .L(L), .STRIDE(1), .CW(CW)) bus1 ();
    toeplitz_acc_if #(.N(N), .L(L), .STRIDE(4), .CW(CW)) bus4 ();

    toeplitz_acc #(.N(N), .L(L), .STRIDE(1), .CW(CW)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    toeplitz_acc #(.N(N), .L(L), .STRIDE(4), .CW(CW)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // ---------------- scoreboard / reference ----------------
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    bit           m1_x[N];
    logic [L-1:0] m1_c[N];
    int unsigned  m1_pos, m1_cnt;
    logic [L-1:0] m1_last;
    logic [L-1:0] exp_q1[$];

    bit           m4_x[N];
    logic [L-1:0] m4_c[N];
    int unsigned  m4_pos, m4_cnt;
    logic [L-1:0] m4_last;
    logic [L-1:0] exp_q4[$];

    int unsigned  adv4, wrap4;

    bit           bx[N];
    logic [L-1:0] bc[N];
    bit           gx[N];
    logic [L-1:0] gc[N];
    logic [L-1:0] golden;

    task automatic check_val(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // hash = M.x : XOR of every column whose raw bit is 1.
    function automatic logic [L-1:0] gf2_hash(input bit x[N], input logic [L-1:0] c[N]);
        logic [L-1:0] h;
        h = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) h = h ^ c[i];
        end
        return h;
    endfunction

    function automatic logic [L-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m1_pos = 0; m1_cnt = 0; m1_last = '0; exp_q1.delete();
        m4_pos = 0; m4_cnt = 0; m4_last = '0; exp_q4.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock of the STRIDE=1 instance: drive at negedge, check, update model.
    task automatic step1(input logic d, input logic v, input logic [L-1:0] col,
                         input logic fl, input logic dr);
        logic last, rdy, adv;
        logic [L-1:0] h;
        @(negedge clk);
        bus1.din = d; bus1.din_valid = v; bus1.cols = col;
        bus1.flush = fl; bus1.dout_ready = dr;
        #1;
        last = (m1_pos == N - 1);
        rdy  = !last || (exp_q1.size() == 0) || dr;
        adv  = v && rdy && !fl;
        check_val("s1_din_ready", L'(bus1.din_ready), L'(rdy));
        check_val("s1_col_adv", L'(bus1.col_adv), L'(adv));
        check_val("s1_col_wrap", L'(bus1.col_wrap), L'(adv && last));
        check_val("s1_dout_valid", L'(bus1.dout_valid), L'(exp_q1.size() != 0));
        check_val("s1_blk_cnt", L'(bus1.blk_cnt), L'(m1_cnt));
        check_val("s1_beat", L'(bus1.dbg_beat), L'(m1_pos));
        if (exp_q1.size() == 0) begin
            check_val("s1_dout_hold", bus1.dout, m1_last);
        end else begin
            check_val("s1_dout", bus1.dout, exp_q1[0]);
            if (dr) begin
                h = exp_q1.pop_front();
                m1_last = h;
            end
        end
        if (fl) begin
            m1_pos = 0;
        end else if (adv) begin
            m1_x[m1_pos] = d;
            m1_c[m1_pos] = col;
            m1_pos++;
            if (m1_pos == N) begin
                exp_q1.push_back(gf2_hash(m1_x, m1_c));
                m1_pos = 0;
                m1_cnt++;
            end
        end
    endtask

    task automatic step4(input logic [3:0] d, input logic v, input logic [4*L-1:0] col,
                         input logic fl, input logic dr);
        logic last, rdy, adv;
        logic [L-1:0] h;
        @(negedge clk);
        bus4.din = d; bus4.din_valid = v; bus4.cols = col;
        bus4.flush = fl; bus4.dout_ready = dr;
        #1;
        last = (m4_pos == N - 4);
        rdy  = !last || (exp_q4.size() == 0) || dr;
        adv  = v && rdy && !fl;
        if (bus4.col_adv)  adv4++;
        if (bus4.col_wrap) wrap4++;
        check_val("s4_din_ready", L'(bus4.din_ready), L'(rdy));
        check_val("s4_col_adv", L'(bus4.col_adv), L'(adv));
        check_val("s4_col_wrap", L'(bus4.col_wrap), L'(adv && last));
        check_val("s4_dout_valid", L'(bus4.dout_valid), L'(exp_q4.size() != 0));
        check_val("s4_blk_cnt", L'(bus4.blk_cnt), L'(m4_cnt));
        check_val("s4_beat", L'(bus4.dbg_beat), L'(m4_pos / 4));
        if (exp_q4.size() == 0) begin
            check_val("s4_dout_hold", bus4.dout, m4_last);
        end else begin
            check_val("s4_dout", bus4.dout, exp_q4[0]);
            if (dr) begin
                h = exp_q4.pop_front();
                m4_last = h;
            end
        end
        if (fl) begin
            m4_pos = 0;
        end else if (adv) begin
            for (int j = 0; j < 4; j++) begin
                m4_x[m4_pos + j] = d[j];
                m4_c[m4_pos + j] = col[j*L +: L];
            end
            m4_pos += 4;
            if (m4_pos == N) begin
                exp_q4.push_back(gf2_hash(m4_x, m4_c));
                m4_pos = 0;
                m4_cnt++;
            end
        end
    endtask

    // Park an instance for one idle clock so the other one can be exercised.
    task automatic park_all();
        @(negedge clk);
        bus1.din_valid = 1'b0; bus1.flush = 1'b0; bus1.dout_ready = 1'b0;
        bus4.din_valid = 1'b0; bus4.flush = 1'b0; bus4.dout_ready = 1'b0;
    endtask

    task automatic run_blk1(input logic dr);
        for (int i = 0; i < N; i++) step1(bx[i], 1'b1, bc[i], 1'b0, dr);
    endtask

    task automatic rand_blk4(input int nbeats, input logic dr);
        for (int k = 0; k < nbeats; k++) begin
            step4(4'($urandom_range(0, 15)), 1'b1, {rand128(), rand128(), rand128(), rand128()}, 1'b0, dr);
        end
    endtask

    task automatic rand_beats1(input int nbeats, input logic dr);
        for (int k = 0; k < nbeats; k++) step1(1'($urandom_range(0, 1)), 1'b1, rand128(), 1'b0, dr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus1.flush = 0; bus1.din = '0; bus1.din_valid = 0; bus1.cols = '0; bus1.dout_ready = 0;
        bus4.flush = 0; bus4.din = '0; bus4.din_valid = 0; bus4.cols = '0; bus4.dout_ready = 0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            gx[i] = 1'($urandom_range(0, 1));
            gc[i] = rand128();
        end
        golden = gf2_hash(gx, gc);

        // Reset state, with din_valid high to show no strobes under reset.
        repeat (3) @(negedge clk);
        bus1.din_valid = 1'b1; bus4.din_valid = 1'b1;
        #1;
        check_val("rst_col_adv1", L'(bus1.col_adv), '0);
        check_val("rst_col_wrap1", L'(bus1.col_wrap), '0);
        check_val("rst_col_adv4", L'(bus4.col_adv), '0);
        check_val("rst_dout_valid", L'(bus1.dout_valid), '0);
        check_val("rst_blk_cnt", L'(bus1.blk_cnt), '0);
        check_val("rst_dout", bus4.dout, '0);
        bus1.din_valid = 1'b0; bus4.din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // All-ones columns, all-ones data: even count of equal columns cancels.
        for (int i = 0; i < N; i++) begin bx[i] = 1'b1; bc[i] = '1; end
        run_blk1(1'b0);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t1_dout_even", bus1.dout, '0);
        check_val("t1_blk_cnt", L'(bus1.blk_cnt), L'(1));
        step1(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // One-hot raw bit selects exactly one column.
        for (int i = 0; i < N; i++) begin bx[i] = (i == 5); bc[i] = rand128(); end
        bc[5] = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        run_blk1(1'b0);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t2_onehot", bus1.dout, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Fresh-run golden block.
        bx = gx; bc = gc;
        run_blk1(1'b0);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t2_golden_fresh", bus1.dout, golden);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b1);
        park_all();

        // STRIDE=4: A=1, B=3 selected on beat 0 only.
        adv4 = 0; wrap4 = 0;
        for (int k = 0; k < N / 4; k++) begin
            if (k == 0) step4(4'b0011, 1'b1, {rand128(), rand128(), 128'h3, 128'h1}, 1'b0, 1'b0);
            else        step4(4'b0000, 1'b1, {rand128(), rand128(), rand128(), rand128()}, 1'b0, 1'b0);
        end
        check_val("t3_adv_count", L'(adv4), L'(64));
        check_val("t3_wrap_count", L'(wrap4), L'(1));
        step4(4'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t3_dout", bus4.dout, 128'h2);
        step4(4'b0, 1'b0, '0, 1'b0, 1'b1);

        // Backpressure: block 2 stalls on its final beat until block 1 leaves.
        rand_blk4(64, 1'b0);
        rand_blk4(63, 1'b0);
        repeat (3) step4(4'hF, 1'b1, {rand128(), rand128(), rand128(), rand128()}, 1'b0, 1'b0);
        check_val("t4_stall_beat", L'(bus4.dbg_beat), L'(63));
        check_val("t4_stall_ready", L'(bus4.din_ready), '0);
        step4(4'($urandom_range(0, 15)), 1'b1, {rand128(), rand128(), rand128(), rand128()}, 1'b0, 1'b1);
        step4(4'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t4_valid_kept", L'(bus4.dout_valid), L'(1));
        check_val("t4_blk_cnt", L'(bus4.blk_cnt), L'(3));
        step4(4'b0, 1'b0, '0, 1'b0, 1'b1);

        // Random traffic with random backpressure and rare flushes.
        for (int k = 0; k < 400; k++) begin
            step4(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  {rand128(), rand128(), rand128(), rand128()},
                  1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
        end
        repeat (2) step4(4'b0, 1'b0, '0, 1'b0, 1'b1);
        park_all();

        // Reset mid-block with a hash held, then a golden block.
        rand_beats1(N, 1'b0);
        rand_beats1(100, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("t5_col_adv", L'(bus1.col_adv), '0);
        check_val("t5_dout_valid", L'(bus1.dout_valid), '0);
        check_val("t5_blk_cnt", L'(bus1.blk_cnt), '0);
        check_val("t5_beat", L'(bus1.dbg_beat), '0);
        check_val("t5_dout", bus1.dout, '0);
        check_val("t5_blk_cnt4", L'(bus4.blk_cnt), '0);
        model_reset();
        bus1.din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bx = gx; bc = gc;
        run_blk1(1'b0);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t5_golden_after_rst", bus1.dout, golden);

        // Flush at beat 40 while the golden hash is still held.
        rand_beats1(40, 1'b0);
        step1(1'b1, 1'b1, rand128(), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_val("t6_beat_zero", L'(bus1.dbg_beat), '0);
        check_val("t6_held_valid", L'(bus1.dout_valid), L'(1));
        check_val("t6_held_dout", bus1.dout, golden);
        for (int i = 0; i < N; i++) begin bx[i] = 1'($urandom_range(0, 1)); bc[i] = rand128(); end
        run_blk1(1'b1);
        step1(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("t6_next_block", bus1.dout, gf2_hash(bx, bc));
        step1(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
